// File: rtl/buttons_event_if.sv
// Button-event bus: debounced levels in, event FIFO head and status out.
interface buttons_event_if;
    logic [3:0] btn_levels;
    logic       event_valid;
    logic       event_ready;
    logic [3:0] event_code;
    logic [2:0] event_count;
    logic       overflow;
    logic       overflow_clr;

    // Event producer (the scheduler)
    modport master (
        input  btn_levels, event_ready, overflow_clr,
        output event_valid, event_code, event_count, overflow
    );

    // Event consumer (CPU/MMIO side)
    modport slave (
        output btn_levels, event_ready, overflow_clr,
        input  event_valid, event_code, event_count, overflow
    );
endinterface

// File: rtl/buttons_event_scheduler.sv
// Button event scheduler: per-button press/release/long/repeat FSMs feeding
// one-entry slots, a round-robin arbiter and an event FIFO drained by valid/ready.
module buttons_event_scheduler #(
    parameter int unsigned LONG_PRESS_TICKS = 50_000_000,
    parameter int unsigned REPEAT_TICKS     = 10_000_000,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic            clk,
    input  logic            rst,
    buttons_event_if.master bus
);
    localparam int unsigned MAX_TICKS = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W     = PTR_W + 1;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_RELEASE = 2'b01;
    localparam logic [1:0] EV_LONG    = 2'b10;
    localparam logic [1:0] EV_REPEAT  = 2'b11;

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} btn_state_t;

    btn_state_t       state     [4];
    logic [CNT_W-1:0] cnt       [4];
    logic [3:0]       slot_full;
    logic [3:0]       slot_code [4];
    logic [1:0]       rr_ptr;
    logic [3:0]       fifo_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [OCC_W-1:0] occ;

    logic [3:0]       gen_c;
    logic [1:0]       gen_type_c [4];
    logic             pop_c;
    logic             accept_c;
    logic             grant_any_c;
    logic [1:0]       grant_idx_c;
    logic [3:0]       grant_c;
    logic [3:0]       push_code_c;
    logic             drop_c;
    logic [OCC_W-1:0] occ_next_c;
    logic [3:0]       head_next_c;

    // Event generation from each button FSM; release beats long/repeat
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            gen_c[i]      = 1'b0;
            gen_type_c[i] = EV_PRESS;
            case (state[i])
                RELEASED: if (bus.btn_levels[i]) gen_c[i] = 1'b1;
                PRESSED: begin
                    if (!bus.btn_levels[i]) begin
                        gen_c[i] = 1'b1; gen_type_c[i] = EV_RELEASE;
                    end else if (cnt[i] == CNT_W'(LONG_PRESS_TICKS - 1)) begin
                        gen_c[i] = 1'b1; gen_type_c[i] = EV_LONG;
                    end
                end
                HELD: begin
                    if (!bus.btn_levels[i]) begin
                        gen_c[i] = 1'b1; gen_type_c[i] = EV_RELEASE;
                    end else if (cnt[i] == CNT_W'(REPEAT_TICKS - 1)) begin
                        gen_c[i] = 1'b1; gen_type_c[i] = EV_REPEAT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin grant, FIFO push/pop bookkeeping and next head entry
    always_comb begin
        logic [1:0] idx;
        idx         = rr_ptr;
        pop_c       = bus.event_valid && bus.event_ready;
        accept_c    = (occ != OCC_W'(FIFO_DEPTH)) || pop_c;
        grant_any_c = 1'b0;
        grant_idx_c = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (accept_c && !grant_any_c && slot_full[idx]) begin
                grant_any_c = 1'b1;
                grant_idx_c = idx;
            end
        end
        grant_c     = grant_any_c ? (4'b0001 << grant_idx_c) : 4'b0000;
        push_code_c = slot_code[grant_idx_c];
        drop_c      = |(gen_c & slot_full & ~grant_c);

        case ({grant_any_c, pop_c})
            2'b10:   occ_next_c = occ + OCC_W'(1);
            2'b01:   occ_next_c = occ - OCC_W'(1);
            default: occ_next_c = occ;
        endcase

        // Head must track the entry behind the popped one, or the bypassed push
        head_next_c = bus.event_code;
        if (pop_c) begin
            if (occ > OCC_W'(1))  head_next_c = fifo_mem[rd_idx + PTR_W'(1)];
            else if (grant_any_c) head_next_c = push_code_c;
            else                  head_next_c = 4'h0;
        end else if (occ == OCC_W'(0) && grant_any_c) begin
            head_next_c = push_code_c;
        end
    end

    // State: button FSMs, pending slots, arbiter pointer, FIFO and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state[i]     <= RELEASED;
                cnt[i]       <= '0;
                slot_code[i] <= '0;
            end
            for (int j = 0; j < int'(FIFO_DEPTH); j++) fifo_mem[j] <= '0;
            slot_full       <= '0;
            rr_ptr          <= '0;
            wr_idx          <= '0;
            rd_idx          <= '0;
            occ             <= '0;
            bus.event_valid <= 1'b0;
            bus.event_code  <= '0;
            bus.event_count <= '0;
            bus.overflow    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    RELEASED: if (bus.btn_levels[i]) begin
                        state[i] <= PRESSED;
                        cnt[i]   <= '0;
                    end
                    PRESSED: begin
                        if (!bus.btn_levels[i]) state[i] <= RELEASED;
                        else if (cnt[i] == CNT_W'(LONG_PRESS_TICKS - 1)) begin
                            state[i] <= HELD;
                            cnt[i]   <= '0;
                        end else cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                    HELD: begin
                        if (!bus.btn_levels[i]) state[i] <= RELEASED;
                        else if (cnt[i] == CNT_W'(REPEAT_TICKS - 1)) cnt[i] <= '0;
                        else cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                    default: state[i] <= RELEASED;
                endcase

                if (gen_c[i] && (!slot_full[i] || grant_c[i])) begin
                    slot_full[i] <= 1'b1;
                    slot_code[i] <= {gen_type_c[i], 2'(i)};
                end else if (grant_c[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end

            if (drop_c)                bus.overflow <= 1'b1;
            else if (bus.overflow_clr) bus.overflow <= 1'b0;

            if (grant_any_c) begin
                rr_ptr           <= grant_idx_c + 2'd1;
                fifo_mem[wr_idx] <= push_code_c;
                wr_idx           <= wr_idx + PTR_W'(1);
            end
            if (pop_c) rd_idx <= rd_idx + PTR_W'(1);

            occ             <= occ_next_c;
            bus.event_count <= 3'(occ_next_c);
            bus.event_valid <= (occ_next_c != OCC_W'(0));
            bus.event_code  <= head_next_c;
        end
    end
endmodule
